// File: rtl/lab7_soc_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID (word 0) and timestamp (word 1) and checks them.
// Latency start->done 4 cycles on a zero-wait slave; stalls on waitrequest, aborts a read after TIMEOUT_CYCLES.
module lab7_soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1520301716,
    parameter bit          USE_RDV            = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic        address_o,
    output logic        read_o,
    input  logic        waitrequest_i,
    input  logic [31:0] readdata_i,
    input  logic        readdatavalid_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        id_mismatch_o,
    output logic        ts_mismatch_o,
    output logic        timeout_o,
    output logic [31:0] id_value_o,
    output logic [31:0] ts_value_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_WT_ID,
        S_RD_TS,
        S_WT_TS,
        S_FINISH
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        auto_q, auto_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        idm_q, idm_d;
    logic        tsm_q, tsm_d;
    logic        to_q, to_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;

    logic [15:0] cnt_inc;
    logic        limit_hit;
    logic        got_data;
    logic        is_ts;

    // Saturating so a very long stall can never wrap back below the limit.
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign limit_hit = (cnt_q >= TO_LIMIT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        auto_d    = auto_q;
        done_d    = done_q;
        pass_d    = pass_q;
        idm_d     = idm_q;
        tsm_d     = tsm_q;
        to_d      = to_q;
        id_d      = id_q;
        ts_d      = ts_q;
        read_o    = 1'b0;
        address_o = 1'b0;
        busy_o    = 1'b0;
        got_data  = 1'b0;
        is_ts     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i || auto_q) begin
                    state_d = S_RD_ID;
                    auto_d  = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    idm_d   = 1'b0;
                    tsm_d   = 1'b0;
                    to_d    = 1'b0;
                    id_d    = '0;
                    ts_d    = '0;
                end
            end

            S_RD_ID, S_RD_TS: begin
                is_ts     = (state_q == S_RD_TS);
                read_o    = 1'b1;
                address_o = is_ts;
                busy_o    = 1'b1;
                cnt_d     = cnt_inc;
                // With readdatavalid, data may still land in the accept cycle itself.
                got_data  = !waitrequest_i && (!USE_RDV || readdatavalid_i);
                if (!got_data && limit_hit) begin
                    to_d    = 1'b1;
                    state_d = S_FINISH;
                end else if (!got_data && !waitrequest_i) begin
                    state_d = is_ts ? S_WT_TS : S_WT_ID;
                end
            end

            S_WT_ID, S_WT_TS: begin
                is_ts     = (state_q == S_WT_TS);
                address_o = is_ts;
                busy_o    = 1'b1;
                cnt_d     = cnt_inc;
                got_data  = readdatavalid_i;
                if (!got_data && limit_hit) begin
                    to_d    = 1'b1;
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                idm_d   = !to_q && (id_q != EXPECTED_ID);
                tsm_d   = !to_q && (ts_q != EXPECTED_TIMESTAMP);
                pass_d  = !to_q && (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP);
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        if (got_data) begin
            if (is_ts) begin
                ts_d    = readdata_i;
                state_d = S_FINISH;
            end else begin
                id_d    = readdata_i;
                cnt_d   = '0;
                state_d = S_RD_TS;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            auto_q  <= AUTO_START;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            idm_q   <= 1'b0;
            tsm_q   <= 1'b0;
            to_q    <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            auto_q  <= auto_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            idm_q   <= idm_d;
            tsm_q   <= tsm_d;
            to_q    <= to_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
        end
    end

    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign id_mismatch_o = idm_q;
    assign ts_mismatch_o = tsm_q;
    assign timeout_o     = to_q;
    assign id_value_o    = id_q;
    assign ts_value_o    = ts_q;

endmodule

// File: tb/tb_lab7_soc_sysid_checker.sv
// Bench: instance A (no readdatavalid, auto start, stalling slave) and instance B (readdatavalid, timeout 8).
// Expected flags, values and latencies come from arithmetic on the slave contents and stall lengths.
module tb_lab7_soc_sysid_checker;

    localparam logic [31:0] EXP_TS   = 32'd1520301716;
    localparam logic [31:0] EXP_ID_A = 32'd0;
    localparam logic [31:0] EXP_ID_B = 32'h1234_5678;
    localparam int          TO_B     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // ---------------- instance A ----------------
    logic        rst_a = 1'b1, start_a = 1'b0;
    logic        addr_a, read_a, wait_a, busy_a, done_a, pass_a, idm_a, tsm_a, to_a;
    logic        rdv_a = 1'b0;
    logic [31:0] rdata_a, idv_a, tsv_a;
    logic [31:0] mem_a [0:1];
    int          wait_len_a = 0, wcnt_a = 0, acc0_a = 0, acc1_a = 0, stab_err_a = 0;
    logic        stall_prev_a = 1'b0, addr_prev_a = 1'b0;

    assign wait_a  = read_a && (wcnt_a < wait_len_a);
    assign rdata_a = mem_a[addr_a];

    always @(posedge clk) begin
        if (read_a && wait_a) wcnt_a <= wcnt_a + 1;
        else                  wcnt_a <= 0;
        if (read_a && !wait_a) begin
            if (addr_a) acc1_a <= acc1_a + 1;
            else        acc0_a <= acc0_a + 1;
        end
        if (stall_prev_a && (read_a !== 1'b1 || addr_a !== addr_prev_a))
            stab_err_a <= stab_err_a + 1;
        stall_prev_a <= read_a && wait_a;
        addr_prev_a  <= addr_a;
    end

    lab7_soc_sysid_checker #(
        .EXPECTED_ID(EXP_ID_A), .EXPECTED_TIMESTAMP(EXP_TS), .USE_RDV(1'b0),
        .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)
    ) dut_a (
        .clock_i(clk), .reset_i(rst_a), .start_i(start_a), .address_o(addr_a), .read_o(read_a),
        .waitrequest_i(wait_a), .readdata_i(rdata_a), .readdatavalid_i(rdv_a), .busy_o(busy_a),
        .done_o(done_a), .pass_o(pass_a), .id_mismatch_o(idm_a), .ts_mismatch_o(tsm_a),
        .timeout_o(to_a), .id_value_o(idv_a), .ts_value_o(tsv_a)
    );

    // ---------------- instance B ----------------
    logic        rst_b = 1'b1, start_b = 1'b0, clr_b = 1'b0;
    logic        addr_b, read_b, rdv_b, busy_b, done_b, pass_b, idm_b, tsm_b, to_b;
    logic        wait_b = 1'b0;
    logic [31:0] rdata_b, idv_b, tsv_b;
    logic [31:0] mem_b [0:1];
    int          dly_b = 0, pcnt_b = 0, acc0_b = 0, acc1_b = 0;
    bit          rdv_en_b = 1'b0, rdv_force_b = 1'b0;
    logic        pend_b = 1'b0, pend_addr_b = 1'b0;

    assign rdv_b   = rdv_force_b ||
                     (rdv_en_b && ((read_b && dly_b == 0) || (pend_b && pcnt_b == dly_b)));
    assign rdata_b = rdv_force_b ? 32'hDEAD_BEEF : mem_b[pend_b ? pend_addr_b : addr_b];

    always @(posedge clk) begin
        if (rst_b || clr_b) begin
            pend_b <= 1'b0;
            pcnt_b <= 0;
        end else if (read_b && !rdv_b) begin
            pend_b      <= 1'b1;
            pcnt_b      <= 1;
            pend_addr_b <= addr_b;
        end else if (pend_b) begin
            if (rdv_b) pend_b <= 1'b0;
            else       pcnt_b <= pcnt_b + 1;
        end
        if (read_b && !rst_b) begin
            if (addr_b) acc1_b <= acc1_b + 1;
            else        acc0_b <= acc0_b + 1;
        end
    end

    lab7_soc_sysid_checker #(
        .EXPECTED_ID(EXP_ID_B), .EXPECTED_TIMESTAMP(EXP_TS), .USE_RDV(1'b1),
        .TIMEOUT_CYCLES(TO_B), .AUTO_START(1'b0)
    ) dut_b (
        .clock_i(clk), .reset_i(rst_b), .start_i(start_b), .address_o(addr_b), .read_o(read_b),
        .waitrequest_i(wait_b), .readdata_i(rdata_b), .readdatavalid_i(rdv_b), .busy_o(busy_b),
        .done_o(done_b), .pass_o(pass_b), .id_mismatch_o(idm_b), .ts_mismatch_o(tsm_b),
        .timeout_o(to_b), .id_value_o(idv_b), .ts_value_o(tsv_b)
    );

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // mode 0: plain run; 1: extra start while busy; 2: extra start during the finish cycle
    task automatic run_a(input logic [31:0] id, input logic [31:0] ts, input int w,
                         input int mode, input bit auto_rel, input string tag);
        int lat, a0, a1;
        mem_a[0]   = id;
        mem_a[1]   = ts;
        wait_len_a = w;
        a0 = acc0_a;
        a1 = acc1_a;
        if (auto_rel) rst_a = 1'b0;
        else          start_a = 1'b1;
        tick();
        start_a = 1'b0;
        lat = 1;
        chk1({tag, ".read1"}, read_a, 1'b1);
        chk1({tag, ".addr1"}, addr_a, 1'b0);
        chk1({tag, ".done_clr"}, done_a, 1'b0);
        while (!done_a && lat < 60) begin
            start_a = (mode == 1 && lat == 2) || (mode == 2 && !busy_a);
            tick();
            lat++;
        end
        start_a = 1'b0;
        chk32({tag, ".latency"}, lat, 4 + 2 * w);
        chk1({tag, ".pass"}, pass_a, (id == EXP_ID_A) && (ts == EXP_TS));
        chk1({tag, ".idm"}, idm_a, id != EXP_ID_A);
        chk1({tag, ".tsm"}, tsm_a, ts != EXP_TS);
        chk1({tag, ".timeout"}, to_a, 1'b0);
        chk32({tag, ".id_value"}, idv_a, id);
        chk32({tag, ".ts_value"}, tsv_a, ts);
        tick();
        tick();
        chk1({tag, ".idle_busy"}, busy_a, 1'b0);
        chk1({tag, ".done_hold"}, done_a, 1'b1);
        chk32({tag, ".reads0"}, acc0_a - a0, 1);
        chk32({tag, ".reads1"}, acc1_a - a1, 1);
    endtask

    task automatic run_b(input logic [31:0] id, input logic [31:0] ts, input bit en,
                         input int dly, input string tag);
        int  lat, a0, a1;
        bit  tmo;
        clr_b = 1'b1;
        tick();
        clr_b    = 1'b0;
        mem_b[0] = id;
        mem_b[1] = ts;
        rdv_en_b = en;
        dly_b    = dly;
        a0 = acc0_b;
        a1 = acc1_b;
        // data may land up to TO_B cycles after the read strobe
        tmo = !en || (dly > TO_B);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        lat = 1;
        while (!done_b && lat < 80) begin
            tick();
            lat++;
        end
        chk32({tag, ".latency"}, lat, tmo ? TO_B + 3 : 2 * (1 + dly) + 2);
        chk1({tag, ".timeout"}, to_b, tmo);
        chk1({tag, ".pass"}, pass_b, !tmo && (id == EXP_ID_B) && (ts == EXP_TS));
        chk1({tag, ".idm"}, idm_b, !tmo && (id != EXP_ID_B));
        chk1({tag, ".tsm"}, tsm_b, !tmo && (ts != EXP_TS));
        chk32({tag, ".reads0"}, acc0_b - a0, 1);
        chk32({tag, ".reads1"}, acc1_b - a1, tmo ? 0 : 1);
        if (!tmo) begin
            chk32({tag, ".id_value"}, idv_b, id);
            chk32({tag, ".ts_value"}, tsv_b, ts);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rid, rts;
        int          polls, a1;

        mem_a[0] = EXP_ID_A; mem_a[1] = EXP_TS;
        mem_b[0] = EXP_ID_B; mem_b[1] = EXP_TS;
        repeat (3) tick();
        chk1("rst.read", read_a, 1'b0);
        chk1("rst.addr", addr_a, 1'b0);
        chk1("rst.busy", busy_a, 1'b0);
        chk1("rst.done", done_a, 1'b0);
        chk1("rst.pass", pass_a, 1'b0);
        chk1("rst.flags", idm_a | tsm_a | to_a, 1'b0);
        chk32("rst.id_value", idv_a, 32'd0);
        chk32("rst.ts_value", tsv_a, 32'd0);
        rst_b = 1'b0;

        // auto start after reset release, zero-wait slave
        run_a(EXP_ID_A, EXP_TS, 0, 0, 1'b1, "a_auto");
        chk1("b_no_autostart", busy_b, 1'b0);
        run_a(EXP_ID_A, EXP_TS + 32'd1, 0, 0, 1'b0, "a_tsbad");
        run_a(EXP_ID_A, EXP_TS, 3, 0, 1'b0, "a_wait3");
        chk32("a_stable_stall", stab_err_a, 0);
        run_a(EXP_ID_A, EXP_TS, 0, 1, 1'b0, "a_start_busy");
        run_a(EXP_ID_A, EXP_TS, 1, 2, 1'b0, "a_start_fin");
        run_a(32'h0000_0001, EXP_TS, 0, 0, 1'b0, "a_idbad");
        for (int i = 0; i < 6; i++) begin
            rid = ($urandom_range(0, 1) == 0) ? EXP_ID_A : $urandom;
            rts = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
            run_a(rid, rts, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, "a_rand");
        end
        chk32("a_stable_all", stab_err_a, 0);

        run_b(EXP_ID_B, EXP_TS, 1'b1, 2, "b_dly2");
        run_b(EXP_ID_B, EXP_TS, 1'b1, 0, "b_same_cycle");
        run_b(EXP_ID_B, EXP_TS, 1'b1, TO_B, "b_edge_ok");
        run_b(EXP_ID_B, EXP_TS, 1'b1, TO_B + 1, "b_edge_late");
        run_b(EXP_ID_B, EXP_TS, 1'b0, 0, "b_no_rdv");
        run_b(32'h0, EXP_TS + 32'd7, 1'b1, 1, "b_both_bad");
        for (int i = 0; i < 4; i++) begin
            rid = ($urandom_range(0, 1) == 0) ? EXP_ID_B : $urandom;
            rts = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
            run_b(rid, rts, 1'b1, $urandom_range(0, TO_B + 2), "b_rand");
        end

        // reset while waiting for the timestamp, then a stray readdatavalid
        clr_b = 1'b1;
        tick();
        clr_b    = 1'b0;
        mem_b[0] = EXP_ID_B;
        mem_b[1] = EXP_TS;
        rdv_en_b = 1'b1;
        dly_b    = 3;
        a1       = acc1_b;
        start_b  = 1'b1;
        tick();
        start_b = 1'b0;
        polls   = 0;
        while (acc1_b == a1 && polls < 40) begin
            tick();
            polls++;
        end
        chk1("b_rst.in_wt_ts", busy_b && !read_b && addr_b, 1'b1);
        rst_b = 1'b1;
        tick();
        rst_b       = 1'b0;
        rdv_force_b = 1'b1;
        chk1("b_rst.read_drop", read_b, 1'b0);
        tick();
        rdv_force_b = 1'b0;
        repeat (2) tick();
        chk1("b_rst.read", read_b, 1'b0);
        chk1("b_rst.busy", busy_b, 1'b0);
        chk1("b_rst.done", done_b, 1'b0);
        chk1("b_rst.pass", pass_b, 1'b0);
        chk1("b_rst.flags", idm_b | tsm_b | to_b, 1'b0);
        chk32("b_rst.id_value", idv_b, 32'd0);
        chk32("b_rst.ts_value", tsv_b, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
